mul_seq: RTL

- Multi-cycle radix-2 shift-add multiplier for the MIPS MULT/MULTU path; the multiply-side counterpart of the combinational divider.
- Produces a 2*WIDTH-bit product split into HI/LO for the HI/LO register file.
- Uses a start/busy/done handshake, so the pipeline stalls on busy instead of holding a long combinational path.

---
 rtl/mul_seq_if.sv | 23 ++
 rtl/mul_seq.sv | 103 ++++++++++
 2 files changed

// File: rtl/mul_seq_if.sv
// Handshake/operand/result bundle between a requester and the shift-add multiplier.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier for MULT/MULTU. Signed operands are reduced to
// magnitudes, multiplied unsigned over WIDTH cycles, and the sign is applied in
// a single fix-up cycle before HI/LO are written.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_seq_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod;

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state and datapath: capture in IDLE, one multiplier bit per RUN edge,
  // sign correction and result write in FIX.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    // Magnitude of 0x80..0 wraps to itself, which is the correct unsigned value.
    a_abs = (bus.is_signed && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
    b_abs = (bus.is_signed && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
    prod  = neg_q ? -acc_q : acc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_abs};
          mplier_d = b_abs;
          neg_d    = bus.is_signed & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        hi_d    = prod[2*WIDTH-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
